// File: rtl/ultrasonido_pkg.sv
// rtl/ultrasonido_pkg.sv - shared types, defaults and echo-width helpers for the HC-SR04 emulator
package ultrasonido_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_MEAS,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  typedef logic [15:0] width_t;

  localparam int US_PER_CM_DEF = 58;

  function automatic logic in_range(input logic [8:0] d, input int max_cm);
    return (d != 9'd0) && (int'(d) <= max_cm);
  endfunction

  // Round-trip echo width in microseconds; distance 0 or beyond range reports no target.
  function automatic width_t calc_width(input logic [8:0] d, input int per_cm,
                                        input int max_cm, input int timeout_us);
    if (in_range(d, max_cm)) return width_t'(int'(d) * per_cm);
    return width_t'(timeout_us);
  endfunction

endpackage

// File: rtl/tick_1us.sv
// rtl/tick_1us.sv - free-running prescaler producing a one-cycle pulse every DIV clocks
module tick_1us #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ultrasonido_emulador.sv
// rtl/ultrasonido_emulador.sv - HC-SR04 responder: qualifies Trigger, returns a distance-coded Echo pulse.
// Optional ULTRASONIDO_JITTER_EN adds 0..7 us of LFSR jitter to in-range echo widths.
module ultrasonido_emulador
  import ultrasonido_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int US_PER_CM   = US_PER_CM_DEF,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 10000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Trigger,
  input  logic [8:0] Distancia,
  output logic       Echo,
  output logic       Busy,
  output logic       TrigError
);

  localparam int     DIV          = CLK_HZ / 1_000_000;
  localparam width_t TRIG_MIN     = width_t'(TRIG_MIN_US);
  localparam width_t BURST_LAST   = width_t'(BURST_US - 1);
  localparam width_t HOLDOFF_LAST = width_t'(HOLDOFF_US - 1);

  state_t state, state_next;
  width_t count, count_next;
  width_t width, width_next;
  logic   trig_error_next;
  logic   trig_meta, trig_sync, trig_prev;
  logic   rise, fall, tick;

`ifdef ULTRASONIDO_JITTER_EN
  logic [15:0] lfsr, lfsr_next;
`endif

  tick_1us #(.DIV(DIV)) u_tick (
    .clk   (Clock),
    .reset (Reset),
    .tick  (tick)
  );

  // Edges come only from the synchronized copy, so a Trigger already high on entering IDLE never counts.
  assign rise = trig_sync & ~trig_prev;
  assign fall = ~trig_sync & trig_prev;
  assign Busy = (state != IDLE);

  always_comb begin
    state_next      = state;
    count_next      = count;
    width_next      = width;
    trig_error_next = 1'b0;
`ifdef ULTRASONIDO_JITTER_EN
    lfsr_next       = lfsr;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = TRIG_MEAS;
          count_next = '0;
        end
      end
      TRIG_MEAS: begin
        if (fall) begin
          count_next = '0;
          if (count >= TRIG_MIN) begin
            state_next = BURST;
            width_next = calc_width(Distancia, US_PER_CM, MAX_CM, TIMEOUT_US);
`ifdef ULTRASONIDO_JITTER_EN
            if (in_range(Distancia, MAX_CM)) width_next = width_next + 16'(lfsr[2:0]);
            lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
          end else begin
            state_next      = IDLE;
            trig_error_next = 1'b1;
          end
        end else if (tick && (count < TRIG_MIN)) begin
          count_next = count + 16'd1;
        end
      end
      BURST: begin
        if (tick) begin
          if (count == BURST_LAST) begin
            state_next = ECHO;
            count_next = '0;
          end else begin
            count_next = count + 16'd1;
          end
        end
      end
      ECHO: begin
        if (tick) begin
          if (count == width - 16'd1) begin
            state_next = HOLDOFF;
            count_next = '0;
          end else begin
            count_next = count + 16'd1;
          end
        end
      end
      HOLDOFF: begin
        if (tick) begin
          if (count == HOLDOFF_LAST) begin
            state_next = IDLE;
            count_next = '0;
          end else begin
            count_next = count + 16'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      width     <= '0;
      Echo      <= 1'b0;
      TrigError <= 1'b0;
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      width     <= width_next;
      Echo      <= (state_next == ECHO);
      TrigError <= trig_error_next;
      trig_meta <= Trigger;
      trig_sync <= trig_meta;
      trig_prev <= trig_sync;
    end
  end

`ifdef ULTRASONIDO_JITTER_EN
  always_ff @(posedge Clock) begin
    if (Reset) lfsr <= 16'hACE1;
    else       lfsr <= lfsr_next;
  end
`endif

endmodule

// File: tb/tb_ultrasonido_emulador.sv
// tb/tb_ultrasonido_emulador.sv - scoreboard bench for ultrasonido_emulador with a scaled-down timing set
module tb_ultrasonido_emulador;

  localparam int CLK_HZ   = 2_000_000;
  localparam int DIV      = 2;
  localparam int TRIG_MIN = 10;
  localparam int BURST    = 20;
  localparam int PERCM    = 2;
  localparam int MAXCM    = 400;
  localparam int TIMEOUT  = 1100;
  localparam int HOLD     = 30;
`ifdef ULTRASONIDO_JITTER_EN
  localparam int JIT = 7;
`else
  localparam int JIT = 0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Trigger;
  logic [8:0] Distancia;
  logic       Echo, Busy, TrigError;

  always #5 Clock = ~Clock;

  ultrasonido_emulador #(
    .CLK_HZ(CLK_HZ), .TRIG_MIN_US(TRIG_MIN), .BURST_US(BURST), .US_PER_CM(PERCM),
    .MAX_CM(MAXCM), .TIMEOUT_US(TIMEOUT), .HOLDOFF_US(HOLD)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Trigger(Trigger), .Distancia(Distancia),
    .Echo(Echo), .Busy(Busy), .TrigError(TrigError)
  );

  typedef struct {
    bit is_echo;
    int lo;
    int hi;
    int fall_cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   skip_fall = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, got, lo, hi);
    end
  endtask

  // Reference: a trigger of at least TRIG_MIN us yields an echo of d*PERCM us (1..MAXCM) or TIMEOUT us.
  function automatic exp_t model(input int tw_us, input int d, input int fall_cyc);
    exp_t e;
    e.fall_cyc = fall_cyc;
    e.is_echo  = (tw_us >= TRIG_MIN);
    if (d >= 1 && d <= MAXCM) begin
      e.lo = d * PERCM;
      e.hi = d * PERCM + JIT;
    end else begin
      e.lo = TIMEOUT;
      e.hi = TIMEOUT;
    end
    return e;
  endfunction

  initial begin : monitor
    bit   echo_prev = 1'b0;
    int   rise_cyc = 0;
    exp_t e;
    forever begin
      @(negedge Clock);
      if (Echo && !echo_prev) begin
        rise_cyc = cyc;
        chk("busy_at_echo", int'(Busy), 1, 1);
        chk("echo_rise_expected", sb.size(), 1, 99);
        if (sb.size() > 0)
          chk("burst_delay", cyc - sb[0].fall_cyc, BURST*DIV - DIV, BURST*DIV + DIV + 4);
      end
      if (!Echo && echo_prev) begin
        if (skip_fall) begin
          skip_fall = 1'b0;
        end else begin
          chk("echo_fall_expected", sb.size(), 1, 99);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("kind_echo", int'(e.is_echo), 1, 1);
            chk("echo_width", cyc - rise_cyc, e.lo*DIV - DIV, e.hi*DIV + DIV);
          end
        end
      end
      if (TrigError) begin
        chk("trigerr_expected", sb.size(), 1, 99);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("kind_trigerr", int'(e.is_echo), 0, 0);
        end
      end
      echo_prev = Echo;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 20000) begin
      @(negedge Clock);
      n++;
    end
    chk("idle_timeout", n, 0, 19999);
  endtask

  task automatic run(input int tw_us, input int d, input bit extra);
    int n;
    @(negedge Clock);
    Distancia = 9'(d);
    Trigger   = 1'b1;
    repeat (tw_us * DIV) @(negedge Clock);
    Trigger = 1'b0;
    sb.push_back(model(tw_us, d, cyc));
    repeat (6) @(negedge Clock);
    Distancia = 9'($urandom_range(0, 511));
    if (tw_us < TRIG_MIN) chk("busy_after_short", int'(Busy), 0, 0);
    if (extra) begin
      n = 0;
      while (!Echo && n < 5000) begin
        @(negedge Clock);
        n++;
      end
      chk("echo_wait", n, 0, 4999);
      repeat (50) @(negedge Clock);
      Distancia = 9'd10;
      Trigger   = 1'b1;
      repeat (12 * DIV) @(negedge Clock);
      Trigger = 1'b0;
    end
    wait_idle();
    repeat ($urandom_range(1, 5)) @(negedge Clock);
  endtask

  task automatic abort_run();
    int n = 0;
    @(negedge Clock);
    Distancia = 9'd300;
    Trigger   = 1'b1;
    repeat (12 * DIV) @(negedge Clock);
    Trigger = 1'b0;
    sb.push_back(model(12, 300, cyc));
    while (!Echo && n < 5000) begin
      @(negedge Clock);
      n++;
    end
    chk("abort_echo_wait", n, 0, 4999);
    repeat (100 * DIV) @(negedge Clock);
    skip_fall = 1'b1;
    void'(sb.pop_front());
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_echo", int'(Echo), 0, 0);
    chk("abort_busy", int'(Busy), 0, 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  initial begin : stimulus
    Reset     = 1'b1;
    Trigger   = 1'b0;
    Distancia = '0;
    repeat (3) @(negedge Clock);
    chk("reset_echo", int'(Echo), 0, 0);
    chk("reset_busy", int'(Busy), 0, 0);
    chk("reset_trigerr", int'(TrigError), 0, 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

    run(12, 100, 1'b0);
    run(5, 100, 1'b0);
    run(3, 0, 1'b0);
    run(12, 0, 1'b0);
    run(12, 450, 1'b0);
    run(12, 1, 1'b0);
    run(12, 400, 1'b0);
    run(12, 401, 1'b0);
    run(12, 511, 1'b1);
    abort_run();
    run(12, 20, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) run($urandom_range(1, 7), $urandom_range(0, 511), 1'b0);
      else                           run($urandom_range(12, 20), $urandom_range(0, 511), 1'b0);
    end

    repeat (10) @(negedge Clock);
    chk("scoreboard_empty", sb.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, want completion", vectors);
    $fatal(1);
  end

endmodule
